// File: rtl/cci_mpf_event_counters.sv
// cci_mpf_event_counters
//
// Bank of N_EVENTS event counters fed by single-cycle strobes from the MPF shims.
// Each counter wraps (SATURATE=0) or sticks at all-ones (SATURATE=1) and keeps a
// sticky overflow flag. snap_req copies every counter and flag into shadow registers
// in the same cycle. clr_valid/clr_mask clears selected counters. An indexed read
// port returns a live or shadow value two cycles after acceptance, with no response
// backpressure.
//
// Ports:
//   clk, reset_n                 clock (rising edge), asynchronous active-low reset
//   enable, evt_in               global count enable and per-counter event strobes
//   clr_valid, clr_mask          clear selected counters and their overflow flags
//   snap_req                     copy all live counters/flags to the shadow bank
//   rd_req_valid/idx/live/ready  read request handshake (live=1 live, 0 shadow)
//   rd_rsp_valid/data/ovf/err    one-cycle read response; fields hold between responses
module cci_mpf_event_counters #(
    parameter int unsigned N_EVENTS  = 6,
    parameter int unsigned CNT_WIDTH = 64,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned IDX_WIDTH = ($clog2(N_EVENTS) > 0) ? $clog2(N_EVENTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [N_EVENTS-1:0]  evt_in,
    input  logic                 clr_valid,
    input  logic [N_EVENTS-1:0]  clr_mask,
    input  logic                 snap_req,
    input  logic                 rd_req_valid,
    input  logic [IDX_WIDTH-1:0] rd_req_idx,
    input  logic                 rd_req_live,
    output logic                 rd_req_ready,
    output logic                 rd_rsp_valid,
    output logic [CNT_WIDTH-1:0] rd_rsp_data,
    output logic                 rd_rsp_ovf,
    output logic                 rd_rsp_err
);

    // Counter bank
    logic [N_EVENTS-1:0]  r_evt_q;
    logic [CNT_WIDTH-1:0] r_cnt        [N_EVENTS];
    logic [N_EVENTS-1:0]  r_ovf;
    logic [CNT_WIDTH-1:0] r_shadow     [N_EVENTS];
    logic [N_EVENTS-1:0]  r_shadow_ovf;

    // Read pipeline
    logic                 r_ready;
    logic                 r_s1_valid;
    logic                 r_s1_live;
    logic                 r_s1_err;
    logic [CNT_WIDTH-1:0] r_s1_live_data;
    logic                 r_s1_live_ovf;
    logic [CNT_WIDTH-1:0] r_s1_shadow_data;
    logic                 r_s1_shadow_ovf;
    logic                 r_rsp_valid;
    logic [CNT_WIDTH-1:0] r_rsp_data;
    logic                 r_rsp_ovf;
    logic                 r_rsp_err;

    logic                 w_accept;
    logic                 w_idx_err;
    logic [CNT_WIDTH-1:0] w_live_data;
    logic                 w_live_ovf;
    logic [CNT_WIDTH-1:0] w_shadow_data;
    logic                 w_shadow_ovf;

    assign w_accept  = rd_req_valid & r_ready;
    assign w_idx_err = (32'(rd_req_idx) >= N_EVENTS);

    // Index decode; out-of-range indices select nothing and are flagged by w_idx_err.
    always_comb begin
        w_live_data   = '0;
        w_live_ovf    = 1'b0;
        w_shadow_data = '0;
        w_shadow_ovf  = 1'b0;
        for (int unsigned i = 0; i < N_EVENTS; i++) begin
            if (rd_req_idx == IDX_WIDTH'(i)) begin
                w_live_data   = r_cnt[i];
                w_live_ovf    = r_ovf[i];
                w_shadow_data = r_shadow[i];
                w_shadow_ovf  = r_shadow_ovf[i];
            end
        end
    end

    // Counters update from the registered strobes; shadows copy pre-update values,
    // so snap+clear in one cycle behaves as read-and-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evt_q      <= '0;
            r_ovf        <= '0;
            r_shadow_ovf <= '0;
            for (int unsigned i = 0; i < N_EVENTS; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_evt_q <= evt_in & {N_EVENTS{enable}};
            if (snap_req) begin
                r_shadow_ovf <= r_ovf;
                for (int unsigned i = 0; i < N_EVENTS; i++) begin
                    r_shadow[i] <= r_cnt[i];
                end
            end
            for (int unsigned i = 0; i < N_EVENTS; i++) begin
                if (clr_valid && clr_mask[i]) begin
                    // Clear wins; a coincident event is dropped.
                    r_cnt[i] <= '0;
                    r_ovf[i] <= 1'b0;
                end else if (r_evt_q[i]) begin
                    if (r_cnt[i] == {CNT_WIDTH{1'b1}}) begin
                        r_ovf[i] <= 1'b1;
                        if (SATURATE == 0) begin
                            r_cnt[i] <= '0;
                        end
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Stage 1 captures both candidate values at the accepting edge, so a live read
    // sees the counter as it stood before that edge's update. Stage 2 selects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready          <= 1'b0;
            r_s1_valid       <= 1'b0;
            r_s1_live        <= 1'b0;
            r_s1_err         <= 1'b0;
            r_s1_live_data   <= '0;
            r_s1_live_ovf    <= 1'b0;
            r_s1_shadow_data <= '0;
            r_s1_shadow_ovf  <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_rsp_data       <= '0;
            r_rsp_ovf        <= 1'b0;
            r_rsp_err        <= 1'b0;
        end else begin
            r_ready    <= 1'b1;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_live        <= rd_req_live;
                r_s1_err         <= w_idx_err;
                r_s1_live_data   <= w_live_data;
                r_s1_live_ovf    <= w_live_ovf;
                r_s1_shadow_data <= w_shadow_data;
                r_s1_shadow_ovf  <= w_shadow_ovf;
            end
            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                if (r_s1_err) begin
                    r_rsp_data <= '0;
                    r_rsp_ovf  <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end else if (r_s1_live) begin
                    r_rsp_data <= r_s1_live_data;
                    r_rsp_ovf  <= r_s1_live_ovf;
                    r_rsp_err  <= 1'b0;
                end else begin
                    r_rsp_data <= r_s1_shadow_data;
                    r_rsp_ovf  <= r_s1_shadow_ovf;
                    r_rsp_err  <= 1'b0;
                end
            end
        end
    end

    assign rd_req_ready = r_ready;
    assign rd_rsp_valid = r_rsp_valid;
    assign rd_rsp_data  = r_rsp_data;
    assign rd_rsp_ovf   = r_rsp_ovf;
    assign rd_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_cci_mpf_event_counters.sv
// tb_cci_mpf_event_counters
//
// Three instances share one stimulus stream: 64-bit wrapping, 4-bit wrapping and
// 4-bit saturating. A behavioural model predicts every output each cycle; directed
// sequences add literal expectations, then a randomized phase runs.
module tb_cci_mpf_event_counters;

    localparam int NI = 3;
    localparam int NE = 6;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [5:0]  evt_in;
    logic        clr_valid;
    logic [5:0]  clr_mask;
    logic        snap_req;
    logic        rd_req_valid;
    logic [2:0]  rd_req_idx;
    logic        rd_req_live;
    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [2:0]  rovf;
    logic [2:0]  rerr;
    logic [63:0] d0;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [63:0] act_d [NI];

    assign act_d[0] = d0;
    assign act_d[1] = 64'(d1);
    assign act_d[2] = 64'(d2);

    cci_mpf_event_counters #(.N_EVENTS(6), .CNT_WIDTH(64), .SATURATE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .evt_in(evt_in),
        .clr_valid(clr_valid), .clr_mask(clr_mask), .snap_req(snap_req),
        .rd_req_valid(rd_req_valid), .rd_req_idx(rd_req_idx), .rd_req_live(rd_req_live),
        .rd_req_ready(rdy[0]), .rd_rsp_valid(rv[0]), .rd_rsp_data(d0),
        .rd_rsp_ovf(rovf[0]), .rd_rsp_err(rerr[0])
    );
    cci_mpf_event_counters #(.N_EVENTS(6), .CNT_WIDTH(4), .SATURATE(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .evt_in(evt_in),
        .clr_valid(clr_valid), .clr_mask(clr_mask), .snap_req(snap_req),
        .rd_req_valid(rd_req_valid), .rd_req_idx(rd_req_idx), .rd_req_live(rd_req_live),
        .rd_req_ready(rdy[1]), .rd_rsp_valid(rv[1]), .rd_rsp_data(d1),
        .rd_rsp_ovf(rovf[1]), .rd_rsp_err(rerr[1])
    );
    cci_mpf_event_counters #(.N_EVENTS(6), .CNT_WIDTH(4), .SATURATE(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .evt_in(evt_in),
        .clr_valid(clr_valid), .clr_mask(clr_mask), .snap_req(snap_req),
        .rd_req_valid(rd_req_valid), .rd_req_idx(rd_req_idx), .rd_req_live(rd_req_live),
        .rd_req_ready(rdy[2]), .rd_rsp_valid(rv[2]), .rd_rsp_data(d2),
        .rd_rsp_ovf(rovf[2]), .rd_rsp_err(rerr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [63:0]      due;
        logic [2:0][63:0] data;
        logic [2:0]       ovf;
        logic             err;
    } rsp_t;

    logic [63:0]     m_cnt   [NI][NE];
    bit              m_ovf   [NI][NE];
    logic [63:0]     m_sh    [NI][NE];
    bit              m_shovf [NI][NE];
    logic [5:0]      m_evtq;
    bit              exp_ready;
    bit              exp_valid;
    logic [63:0]     exp_data [NI];
    bit              exp_ovf  [NI];
    bit              exp_err;
    longint unsigned edge_n;
    rsp_t            pend[$];

    function automatic logic [63:0] cnt_max(input int k);
        return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd15;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < NE; i++) begin
                m_cnt[k][i] = 0; m_ovf[k][i] = 0; m_sh[k][i] = 0; m_shovf[k][i] = 0;
            end
            exp_data[k] = 0;
            exp_ovf[k]  = 0;
        end
        m_evtq    = 0;
        exp_ready = 0;
        exp_valid = 0;
        exp_err   = 0;
        pend.delete();
    endtask

    // One rising edge: reads/snapshots see values from before the edge.
    task automatic model_step();
        rsp_t r;
        int   idx;
        if (!reset_n) return;
        edge_n++;
        exp_valid = 0;
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            r = pend.pop_front();
            exp_valid = 1;
            exp_err   = r.err;
            for (int k = 0; k < NI; k++) begin
                exp_data[k] = r.data[k];
                exp_ovf[k]  = r.ovf[k];
            end
        end
        if (rd_req_valid && exp_ready) begin
            idx   = int'(rd_req_idx);
            r     = '0;
            r.due = edge_n + 1;
            r.err = (idx >= NE);
            if (!r.err) begin
                for (int k = 0; k < NI; k++) begin
                    r.data[k] = rd_req_live ? m_cnt[k][idx] : m_sh[k][idx];
                    r.ovf[k]  = rd_req_live ? m_ovf[k][idx] : m_shovf[k][idx];
                end
            end
            pend.push_back(r);
        end
        exp_ready = 1;
        if (snap_req) begin
            m_sh    = m_cnt;
            m_shovf = m_ovf;
        end
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < NE; i++) begin
                if (clr_valid && clr_mask[i]) begin
                    m_cnt[k][i] = 0;
                    m_ovf[k][i] = 0;
                end else if (m_evtq[i]) begin
                    if (m_cnt[k][i] == cnt_max(k)) begin
                        m_ovf[k][i] = 1;
                        if (k != 2) m_cnt[k][i] = 0;
                    end else begin
                        m_cnt[k][i] = m_cnt[k][i] + 1;
                    end
                end
            end
        end
        m_evtq = enable ? evt_in : 6'd0;
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < NI; k++) begin
                    chk("ready", k, 64'(rdy[k]), 64'(exp_ready));
                    chk("rsp_valid", k, 64'(rv[k]), 64'(exp_valid));
                    chk("rsp_data", k, act_d[k], exp_data[k]);
                    chk("rsp_ovf", k, 64'(rovf[k]), 64'(exp_ovf[k]));
                    chk("rsp_err", k, 64'(rerr[k]), 64'(exp_err));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [63:0] g_data [NI];
    bit          g_ovf  [NI];
    bit          g_err  [NI];

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_all();
        evt_in = 0;
        tick();
        clr_valid = 1; clr_mask = 6'h3F;
        tick();
        clr_valid = 0; clr_mask = 0;
    endtask

    task automatic pulse(input logic [5:0] m, input int n);
        for (int j = 0; j < n; j++) begin
            evt_in = m;
            tick();
        end
        evt_in = 0;
    endtask

    // Issue one read; checks the response arrives exactly two cycles later.
    task automatic do_read(input int idx, input bit live);
        rd_req_valid = 1; rd_req_idx = 3'(idx); rd_req_live = live;
        tick();
        rd_req_valid = 0;
        chk("lat_early", 0, 64'(rv), 64'd0);
        tick();
        chk("lat_due", 0, 64'(rv), 64'd7);
        for (int k = 0; k < NI; k++) begin
            g_data[k] = act_d[k]; g_ovf[k] = rovf[k]; g_err[k] = rerr[k];
        end
    endtask

    task automatic expect_rd(input string name, input logic [63:0] e0, input logic [63:0] e1,
                             input logic [63:0] e2, input logic [2:0] eovf, input bit eerr);
        chk(name, 0, g_data[0], e0);
        chk(name, 1, g_data[1], e1);
        chk(name, 2, g_data[2], e2);
        for (int k = 0; k < NI; k++) begin
            chk({name, "_ovf"}, k, 64'(g_ovf[k]), 64'(eovf[k]));
            chk({name, "_err"}, k, 64'(g_err[k]), 64'(eerr));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 0; enable = 0; evt_in = 0; clr_valid = 0; clr_mask = 0; snap_req = 0;
        rd_req_valid = 0; rd_req_idx = 0; rd_req_live = 0; edge_n = 0;
        model_reset();
        chk_en = 1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", 0, 64'(rdy), 64'd0);
        chk("reset_data", 0, d0, 64'd0);
        reset_n = 1;
        tick();
        chk("ready_after_reset", 0, 64'(rdy), 64'd7);
        enable = 1;

        // 1: five events on counter 2, snapshot, shadow read
        pulse(6'b000100, 5);
        tick(); tick();
        snap_req = 1; tick(); snap_req = 0;
        do_read(2, 0);
        expect_rd("t1_shadow", 64'd5, 64'd5, 64'd5, 3'b000, 0);

        // 2: 17 events on counter 0: wrap vs saturate at 4 bits
        clear_all();
        pulse(6'b000001, 17);
        tick(); tick();
        do_read(0, 1);
        expect_rd("t2_live", 64'd17, 64'd1, 64'd15, 3'b110, 0);

        // 3: read-and-clear with a coincident, dropped event
        clear_all();
        pulse(6'b000001, 7);
        tick();
        evt_in = 6'b000001; tick(); evt_in = 0;
        clr_valid = 1; clr_mask = 6'b000001; snap_req = 1;
        tick();
        clr_valid = 0; clr_mask = 0; snap_req = 0;
        tick();
        do_read(0, 0);
        expect_rd("t3_shadow", 64'd7, 64'd7, 64'd7, 3'b000, 0);
        do_read(0, 1);
        expect_rd("t3_live", 64'd0, 64'd0, 64'd0, 3'b000, 0);

        // 4: enable low blocks events
        clear_all();
        enable = 0;
        pulse(6'h3F, 10);
        tick(); tick();
        for (int i = 0; i < NE; i++) begin
            do_read(i, 1);
            expect_rd("t4_disabled", 64'd0, 64'd0, 64'd0, 3'b000, 0);
        end
        enable = 1;
        pulse(6'b000010, 1);
        tick(); tick();
        do_read(1, 1);
        expect_rd("t4_enabled", 64'd1, 64'd1, 64'd1, 3'b000, 0);

        // 5: out-of-range indices, then back-to-back reads in order
        do_read(6, 0);
        expect_rd("t5_idx6", 64'd0, 64'd0, 64'd0, 3'b000, 1);
        do_read(7, 1);
        expect_rd("t5_idx7", 64'd0, 64'd0, 64'd0, 3'b000, 1);
        clear_all();
        for (int j = 0; j < NE; j++) begin
            evt_in = 6'h3F << j;
            tick();
        end
        evt_in = 0;
        tick(); tick();
        for (int j = 0; j < 8; j++) begin
            rd_req_valid = (j < NE); rd_req_idx = 3'(j); rd_req_live = 1;
            tick();
            if (j >= 1 && j <= NE) begin
                chk("t5_b2b_valid", j, 64'(rv), 64'd7);
                chk("t5_b2b_data", j, d0, 64'(j));
                chk("t5_b2b_data4", j, 64'(d1), 64'(j));
            end else if (j == 7) begin
                chk("t5_b2b_tail", j, 64'(rv), 64'd0);
            end
        end
        rd_req_valid = 0;

        // 6: reset with two reads in flight
        rd_req_valid = 1; rd_req_idx = 3'd4; rd_req_live = 1;
        tick();
        rd_req_idx = 3'd5;
        tick();
        rd_req_valid = 0;
        #2;
        reset_n = 0;
        model_reset();
        #1;
        chk("t6_rst_valid", 0, 64'(rv), 64'd0);
        chk("t6_rst_data", 0, d0, 64'd0);
        tick();
        reset_n = 1;
        chk("t6_ready_low", 0, 64'(rdy), 64'd0);
        tick();
        chk("t6_no_rsp", 0, 64'(rv), 64'd0);
        tick();
        chk("t6_no_rsp2", 0, 64'(rv), 64'd0);
        do_read(5, 1);
        expect_rd("t6_live_after", 64'd0, 64'd0, 64'd0, 3'b000, 0);
        do_read(5, 0);
        expect_rd("t6_shadow_after", 64'd0, 64'd0, 64'd0, 3'b000, 0);

        // Randomized phase against the model
        for (int c = 0; c < 3000; c++) begin
            if (!reset_n) reset_n = 1;
            enable       = ($urandom_range(0, 7) != 0);
            evt_in       = 6'($urandom);
            clr_valid    = ($urandom_range(0, 11) == 0);
            clr_mask     = 6'($urandom);
            snap_req     = ($urandom_range(0, 9) == 0);
            rd_req_valid = 1'($urandom);
            rd_req_idx   = 3'($urandom_range(0, 7));
            rd_req_live  = 1'($urandom);
            if ($urandom_range(0, 699) == 0) begin
                #2;
                reset_n = 0;
                model_reset();
            end
            tick();
        end

        rd_req_valid = 0; evt_in = 0; clr_valid = 0; snap_req = 0;
        tick(); tick();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cci_mpf_event_counters.md
Name: cci_mpf_event_counters

Overview:
Parametrised event-counter bank that turns single-cycle event strobes from MPF shims (VTP hit/miss, WRO conflicts, etc.) into readable counters. It replaces ad-hoc fixed-width counters in the CSR manager with a generic bank of N counters with configurable width, wrap/saturate mode, atomic snapshot, selective clear and a pipelined indexed read port. It sits inside the CSR manager, between shim event wires and the MMIO read path.

Parameters:
N_EVENTS, 6, number of event inputs/counters (>=1)
CNT_WIDTH, 64, counter width in bits (>=2)
SATURATE, 0, 0 = counters wrap at max, 1 = counters stick at all-ones
IDX_WIDTH, ($clog2(N_EVENTS) > 0 ? $clog2(N_EVENTS) : 1), read index width

Ports:
clk  input  1  clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  global count enable, sampled with evt_in
evt_in  input  N_EVENTS  one-cycle event strobes, one bit per counter
clr_valid  input  1  clear request this cycle
clr_mask  input  N_EVENTS  counters to clear when clr_valid
snap_req  input  1  copy all live counters to shadow registers
rd_req_valid  input  1  read request
rd_req_idx  input  IDX_WIDTH  counter index
rd_req_live  input  1  1 = read live counter, 0 = read shadow
rd_req_ready  output  1  request accepted when valid & ready
rd_rsp_valid  output  1  response strobe, one cycle
rd_rsp_data  output  CNT_WIDTH  counter value
rd_rsp_ovf  output  1  sticky overflow flag of that counter
rd_rsp_err  output  1  index >= N_EVENTS

Behaviour:
- Reset (reset_n low, async): evt_q, all counters, shadows, overflow and shadow-overflow flags, read pipeline cleared; rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_ovf=0, rd_rsp_err=0. rd_req_ready=1 from first clock edge after reset_n deasserts, constant thereafter.
- Input stage: evt_q <= evt_in & {N_EVENTS{enable}}. Counters update from evt_q, so an event at cycle t is visible in live counter at t+2 edge (readable by request issued t+2).
- Counter update per i, priority order:
  1. clr_valid & clr_mask[i]: cnt=0, ovf=0; evt_q[i] same cycle is dropped.
  2. evt_q[i] and cnt==all-ones: SATURATE=0 -> cnt=0; SATURATE=1 -> cnt unchanged; ovf=1 either way.
  3. evt_q[i]: cnt=cnt+1 (CNT_WIDTH arithmetic).
  4. else hold. ovf is sticky until cleared.
- Snapshot: snap_req in cycle t -> shadow[i], shadow_ovf[i] <= cnt[i], ovf[i] as registered at start of t (pre-update). All N copied atomically. snap_req with clr_valid same cycle = read-and-clear: shadow gets pre-clear value, live goes 0.
- Read pipeline, no response backpressure (MMIO):
  stage 1 (edge after acceptance): register idx, live flag, err = (idx >= N_EVENTS).
  stage 2: mux live/shadow value and flag into rd_rsp_* registers; rd_rsp_valid=1 for one cycle.
  Response exactly 2 cycles after accepting edge. One request per cycle sustained; responses in request order.
- Live read returns counter value as registered at stage-1 edge (updates in that cycle not included).
- err: rd_rsp_data=0, rd_rsp_ovf=0, rd_rsp_err=1. Else rd_rsp_err=0.
- rd_rsp_data/ovf/err hold last value when rd_rsp_valid=0.
- Reset mid-operation: in-flight reads dropped, no response emitted after reset; counters restart from 0.
- enable low: evt_in ignored; clear, snapshot and reads still operate.

Test Plan:
1. Reset, enable=1, 5 pulses on evt_in[2], snap_req, read idx 2 shadow -> rd_rsp_valid exactly 2 cycles after accept, data 5, ovf 0, err 0.
2. CNT_WIDTH=4, SATURATE=0, 17 pulses evt_in[0] -> live read data 1, ovf 1; SATURATE=1 same stimulus -> data 15, ovf 1.
3. Counter 0 = 7; clr_valid, clr_mask=1, snap_req and evt_q[0] all same cycle -> shadow read 7, live read 0, ovf 0.
4. enable=0, 10 pulses on all inputs -> all live reads 0; enable=1, 1 pulse evt_in[1] -> live idx 1 = 1.
5. N_EVENTS=6, read idx 6 and idx 7 -> data 0, err 1; back-to-back reads idx 0..5 each cycle -> 6 consecutive responses in order.
6. reset_n low for 1 cycle while two reads in flight with counters nonzero -> no rd_rsp_valid, all outputs 0, subsequent reads return 0.
